// File: rtl/tpu_writeback_dma_if.sv
// Bus bundle for the writeback DMA: Output Buffer read port plus the AXI4 write
// channels (AW, W, B). The DMA side uses "master", the memory/DDR side "slave".
interface tpu_writeback_dma_if #(
    parameter int W      = 4,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] buf_rd_addr;
    logic              buf_rd_en;
    logic [32*W-1:0]   buf_rd_data;

    logic [31:0]       m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;

    modport master (
        output buf_rd_addr, buf_rd_en,
        input  buf_rd_data,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        input  buf_rd_addr, buf_rd_en,
        output buf_rd_data,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/tpu_writeback_dma.sv
// Writeback sequencer: per row, read one Output Buffer row, issue one INCR burst of
// W 32-bit beats on AXI4, collect BRESP; pulse done_irq after the last row.
module tpu_writeback_dma #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 4,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_pulse,
    input  logic [31:0]           dest_addr,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [15:0]           length,
    output logic                  busy,
    output logic                  done_irq,
    output logic                  error,
    output logic [2:0]            dbg_state_o,
    tpu_writeback_dma_if.master   bus
);
    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int DW = DATA_WIDTH_ACCUM;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(W - 1);
    localparam logic [31:0]   ROW_BYTES = 32'(W * 4);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LATCH, S_AW, S_WD, S_BR, S_DONE
    } state_t;

    state_t                state_q;
    logic [31:0]           dest_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [15:0]           len_q;
    logic [15:0]           row_q;
    logic [BW-1:0]         beat_q;
    logic [DW*W-1:0]       row_data_q;
    logic                  busy_q, done_q, error_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [31:0]           awaddr_q, wdata_q;

    logic [15:0]   row_inc;
    logic [BW-1:0] beat_inc;
    assign row_inc  = row_q + 16'd1;
    assign beat_inc = beat_q + BW'(1);

    // Valid/ready: every valid is a register that, once raised, holds itself and its
    // payload until the cycle whose rising edge sees valid & ready both high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dest_q     <= '0;
            src_q      <= '0;
            len_q      <= '0;
            row_q      <= '0;
            beat_q     <= '0;
            row_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_pulse) begin
                        dest_q  <= dest_addr;
                        src_q   <= src_addr;
                        len_q   <= length;
                        row_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (length == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_addr;
                        end
                    end
                end
                S_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    row_data_q <= bus.buf_rd_data;
                    awaddr_q   <= dest_q + 32'(row_q) * ROW_BYTES;
                    awvalid_q  <= 1'b1;
                    state_q    <= S_AW;
                end
                S_AW: begin
                    if (bus.m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= row_data_q[DW-1:0];
                        wlast_q   <= (LAST_BEAT == '0);
                        beat_q    <= '0;
                        state_q   <= S_WD;
                    end
                end
                S_WD: begin
                    if (bus.m_axi_wready) begin
                        if (beat_q == LAST_BEAT) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_BR;
                        end else begin
                            beat_q  <= beat_inc;
                            wdata_q <= row_data_q[int'(beat_inc)*DW +: DW];
                            wlast_q <= (beat_inc == LAST_BEAT);
                        end
                    end
                end
                S_BR: begin
                    if (bus.m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (bus.m_axi_bresp != 2'b00) error_q <= 1'b1;
                        row_q <= row_inc;
                        if (row_inc == len_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_q + row_inc[ADDR_WIDTH-1:0];
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done_irq      = done_q;
    assign error         = error_q;
    assign dbg_state_o   = state_q;

    assign bus.buf_rd_en     = rd_en_q;
    assign bus.buf_rd_addr   = rd_addr_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = 8'(W - 1);
    assign bus.m_axi_awsize  = 3'b010;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = 4'hF;
    assign bus.m_axi_wlast   = wlast_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
endmodule

// File: tb/tb_tpu_writeback_dma.sv
// Directed bench for tpu_writeback_dma: Output Buffer model, AXI slave responder
// with optional stalls, and a scoreboard of expected reads, bursts and beats.
module tb_tpu_writeback_dma;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pulse;
    logic [31:0] dest_addr;
    logic [9:0]  src_addr;
    logic [15:0] length;
    logic        busy, done_irq, error;
    logic [2:0]  dbg_state;

    tpu_writeback_dma_if #(.W(4), .ADDR_W(10)) bus();

    tpu_writeback_dma #(
        .SYSTOLIC_ARRAY_WIDTH(4),
        .DATA_WIDTH_ACCUM(32),
        .ADDR_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_pulse(start_pulse),
        .dest_addr(dest_addr),
        .src_addr(src_addr),
        .length(length),
        .busy(busy),
        .done_irq(done_irq),
        .error(error),
        .dbg_state_o(dbg_state),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] mem [0:1023];
    logic [31:0]  exp_aw_q[$];
    logic [32:0]  exp_w_q[$];
    logic [9:0]   exp_rd_q[$];

    int max_stall = 0;
    int err_row = -1;
    int b_idx = 0, b_pending = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit aw_armed = 0, w_armed = 0, b_armed = 0, aw_hold = 0, w_hold = 0;
    logic [31:0] aw_held;
    logic [32:0] w_held;
    int done_cnt = 0, busy_cnt = 0, rd_cnt = 0, aw_total = 0, w_seen = 0, w_rows_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output Buffer: registered read, data one cycle after the strobe
    always @(posedge clk) if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];

    // Slave responder and monitor; runs on the falling edge, away from DUT updates
    initial begin
        forever begin
            @(negedge clk);
            if (done_irq) begin
                done_cnt++;
                check_eq("busy_at_done", 64'(busy), 64'd1);
            end
            if (busy) busy_cnt++;
            if (bus.buf_rd_en) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) check_eq("rd_extra", 64'd1, 64'd0);
                else check_eq("rd_addr", 64'(bus.buf_rd_addr), 64'(exp_rd_q.pop_front()));
            end
            // B before W so a response never rises in the same cycle as its wlast
            if (b_pending > 0) begin
                if (!b_armed) begin
                    b_cnt = int'($urandom_range(max_stall, 0));
                    b_armed = 1;
                end
                if (b_cnt == 0) begin
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = (b_idx == err_row) ? 2'b10 : 2'b00;
                    if (bus.m_axi_bready) begin
                        b_pending--;
                        b_idx++;
                        b_armed = 0;
                    end
                end else begin
                    bus.m_axi_bvalid = 1'b0;
                    b_cnt--;
                end
            end else begin
                bus.m_axi_bvalid = 1'b0;
                bus.m_axi_bresp  = 2'b00;
            end
            if (bus.m_axi_awvalid) begin
                if (aw_hold) check_eq("aw_stable", 64'(bus.m_axi_awaddr), 64'(aw_held));
                if (!aw_armed) begin
                    aw_cnt = int'($urandom_range(max_stall, 0));
                    aw_armed = 1;
                end
                if (aw_cnt == 0) begin
                    bus.m_axi_awready = 1'b1;
                    aw_armed = 0;
                    aw_hold = 0;
                    aw_total++;
                    check_eq("awlen", 64'(bus.m_axi_awlen), 64'd3);
                    check_eq("awsize_burst", 64'({bus.m_axi_awsize, bus.m_axi_awburst}), 64'({3'b010, 2'b01}));
                    if (exp_aw_q.size() == 0) check_eq("aw_extra", 64'd1, 64'd0);
                    else check_eq("awaddr", 64'(bus.m_axi_awaddr), 64'(exp_aw_q.pop_front()));
                end else begin
                    bus.m_axi_awready = 1'b0;
                    aw_cnt--;
                    aw_hold = 1;
                    aw_held = bus.m_axi_awaddr;
                end
            end else begin
                bus.m_axi_awready = (max_stall == 0);
                aw_hold = 0;
            end
            if (bus.m_axi_wvalid) begin
                if (w_hold) check_eq("w_stable", 64'({bus.m_axi_wlast, bus.m_axi_wdata}), 64'(w_held));
                if (!w_armed) begin
                    w_cnt = int'($urandom_range(max_stall, 0));
                    w_armed = 1;
                end
                if (w_cnt == 0) begin
                    bus.m_axi_wready = 1'b1;
                    w_armed = 0;
                    w_hold = 0;
                    w_seen++;
                    check_eq("w_after_aw", 64'(aw_total > w_rows_done), 64'd1);
                    check_eq("wstrb", 64'(bus.m_axi_wstrb), 64'hF);
                    if (exp_w_q.size() == 0) check_eq("w_extra", 64'd1, 64'd0);
                    else check_eq("wbeat", 64'({bus.m_axi_wlast, bus.m_axi_wdata}), 64'(exp_w_q.pop_front()));
                    if (bus.m_axi_wlast) begin
                        b_pending++;
                        w_rows_done++;
                    end
                end else begin
                    bus.m_axi_wready = 1'b0;
                    w_cnt--;
                    w_hold = 1;
                    w_held = {bus.m_axi_wlast, bus.m_axi_wdata};
                end
            end else begin
                bus.m_axi_wready = (max_stall == 0);
                w_hold = 0;
            end
        end
    end

    task automatic reset_resp();
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_rd_q.delete();
        aw_armed = 0; w_armed = 0; b_armed = 0; aw_hold = 0; w_hold = 0;
        b_pending = 0; b_idx = 0;
        w_rows_done = aw_total;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
    endtask

    task automatic push_row(input logic [31:0] dest, input logic [9:0] src, input int r);
        logic [9:0] ra;
        ra = src + 10'(r);
        exp_rd_q.push_back(ra);
        exp_aw_q.push_back(dest + 32'(r) * 32'd16);
        for (int b = 0; b < 4; b++) exp_w_q.push_back({b == 3, mem[ra][b*32 +: 32]});
    endtask

    task automatic do_start(input logic [31:0] dest, input logic [9:0] src, input logic [15:0] len);
        @(negedge clk);
        start_pulse = 1'b1;
        dest_addr   = dest;
        src_addr    = src;
        length      = len;
        @(negedge clk);
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > base) begin
                got = 1;
                break;
            end
        end
        check_eq("done_timeout", 64'(got), 64'd1);
    endtask

    task automatic run_xfer(input logic [31:0] dest, input logic [9:0] src, input logic [15:0] len,
                            input logic exp_err, output int busy_cycles);
        int base_done, base_busy, base_rd;
        base_done = done_cnt;
        base_busy = busy_cnt;
        base_rd   = rd_cnt;
        b_idx     = 0;
        do_start(dest, src, len);
        check_eq("err_clr_on_start", 64'(error), 64'd0);
        wait_done(base_done, 3000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_once", 64'(done_cnt - base_done), 64'd1);
        check_eq("aw_left", 64'(exp_aw_q.size()), 64'd0);
        check_eq("w_left", 64'(exp_w_q.size()), 64'd0);
        check_eq("rd_count", 64'(rd_cnt - base_rd), 64'(len));
        check_eq("error_end", 64'(error), 64'(exp_err));
        check_eq("busy_end", 64'(busy), 64'd0);
        busy_cycles = busy_cnt - base_busy;
    endtask

    initial begin : main
        int bc, base_done, base_busy, base_rd, base_aw, base_w;
        bit hit;
        rst_n = 1'b0; start_pulse = 1'b0; dest_addr = '0; src_addr = '0; length = '0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
        bus.buf_rd_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", 64'({busy, done_irq, error, bus.buf_rd_en, bus.m_axi_awvalid,
                                  bus.m_axi_wvalid, bus.m_axi_bready}), 64'd0);
        check_eq("rst_data", 64'({bus.m_axi_awaddr, bus.m_axi_wdata}), 64'd0);
        check_eq("rst_rdaddr_state", 64'({bus.buf_rd_addr, dbg_state}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // two rows, zero-wait slave, hand-computed bursts
        mem[40] = {32'd0, 32'd0, 32'd101, 32'd71};
        mem[41] = {32'd0, 32'd0, 32'd221, 32'd151};
        exp_rd_q.push_back(10'd40);
        exp_rd_q.push_back(10'd41);
        exp_aw_q.push_back(32'h8000_0000);
        exp_aw_q.push_back(32'h8000_0010);
        exp_w_q.push_back({1'b0, 32'd71});
        exp_w_q.push_back({1'b0, 32'd101});
        exp_w_q.push_back({1'b0, 32'd0});
        exp_w_q.push_back({1'b1, 32'd0});
        exp_w_q.push_back({1'b0, 32'd151});
        exp_w_q.push_back({1'b0, 32'd221});
        exp_w_q.push_back({1'b0, 32'd0});
        exp_w_q.push_back({1'b1, 32'd0});
        run_xfer(32'h8000_0000, 10'd40, 16'd2, 1'b0, bc);
        check_eq("busy_cycles_2rows", 64'(bc), 64'd17);

        // zero length: done in the cycle right after the start cycle
        base_done = done_cnt; base_busy = busy_cnt; base_rd = rd_cnt; base_aw = aw_total;
        do_start(32'h0000_1000, 10'd5, 16'd0);
        check_eq("len0_done_next", 64'({done_irq, busy}), 64'b11);
        repeat (4) @(posedge clk);
        #1;
        check_eq("len0_done_cnt", 64'(done_cnt - base_done), 64'd1);
        check_eq("len0_busy_cycles", 64'(busy_cnt - base_busy), 64'd1);
        check_eq("len0_no_rd_aw", 64'((rd_cnt - base_rd) + (aw_total - base_aw)), 64'd0);

        // random stalls on all three channels
        max_stall = 5;
        for (int r = 0; r < 3; r++) push_row(32'h1000_0040, 10'd200, r);
        run_xfer(32'h1000_0040, 10'd200, 16'd3, 1'b0, bc);
        max_stall = 0;

        // error response on row 0; row 1 still written; next start clears error
        for (int r = 0; r < 2; r++) push_row(32'h2000_0000, 10'd300, r);
        err_row = 0;
        run_xfer(32'h2000_0000, 10'd300, 16'd2, 1'b1, bc);
        err_row = -1;
        push_row(32'h2000_1000, 10'd310, 0);
        run_xfer(32'h2000_1000, 10'd310, 16'd1, 1'b0, bc);

        // reset while beat 2 is on the bus
        base_w = w_seen;
        push_row(32'h3000_0000, 10'd100, 0);
        do_start(32'h3000_0000, 10'd100, 16'd1);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (w_seen == base_w + 2 && bus.m_axi_wvalid) begin
                hit = 1;
                break;
            end
        end
        check_eq("rst_reach_beat2", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valids", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                       busy, done_irq, bus.buf_rd_en}), 64'd0);
        check_eq("midrst_data", 64'({bus.m_axi_awaddr, bus.m_axi_wdata}), 64'd0);
        check_eq("midrst_state", 64'(dbg_state), 64'd0);
        reset_resp();
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) push_row(32'h3000_0100, 10'd120, r);
        run_xfer(32'h3000_0100, 10'd120, 16'd2, 1'b0, bc);

        // second start mid-transfer is ignored; source row address wraps
        for (int r = 0; r < 2; r++) push_row(32'h4000_0000, 10'd1023, r);
        base_done = done_cnt; base_rd = rd_cnt;
        b_idx = 0;
        do_start(32'h4000_0000, 10'd1023, 16'd2);
        repeat (4) @(negedge clk);
        check_eq("busy_before_restart", 64'(busy), 64'd1);
        do_start(32'h5555_0000, 10'd7, 16'd9);
        wait_done(base_done, 3000);
        repeat (20) @(posedge clk);
        #1;
        check_eq("ign_done_once", 64'(done_cnt - base_done), 64'd1);
        check_eq("ign_rd_count", 64'(rd_cnt - base_rd), 64'd2);
        check_eq("ign_aw_left", 64'(exp_aw_q.size() + exp_w_q.size()), 64'd0);
        check_eq("ign_idle", 64'({busy, dbg_state}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
